// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address-width helper used by the
// register file, its scoreboard and the hazard unit.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Never returns 0, so a degenerate register count still yields a legal port width.
  function automatic int addr_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared
// at writeback, wiped by a pipeline flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS    = NREGS_DEFAULT,
  parameter int  NWR      = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NWR-1:0]   we,
  input  logic [NWR*AW-1:0] wa,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             sb_flush,
  output logic [NREGS-1:0] busy,
  output logic             busy_any
);

  logic [NREGS-1:0] busy_nxt;

  // Later statements override earlier ones: clear < set < flush < zero-reg.
  always_comb begin
    // NOTE: busy_nxt is given a full default first so no path leaves it unassigned (no latch), and blocking '=' lets each later rule override the earlier ones within the block.
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (sb_set)        busy_nxt[sb_addr] = 1'b1;
    if (sb_flush)      busy_nxt          = '0;
    if (ZERO_REG != 0) busy_nxt[0]       = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port pipeline register file with optional same-cycle write bypass and
// an integrated pending-write scoreboard for hazard detection.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEFAULT,
  parameter int  NREGS    = NREGS_DEFAULT,
  parameter int  NRD      = 2,
  parameter int  NWR      = 1,
  parameter int  BYPASS   = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                sb_flush,
  output logic                busy_any
);

  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp_sb: NWR must be 1 or 2");
  end
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("regfile_mp_sb: NREGS must be a power of two and at least 2");
  end

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;

  // NOTE: the array is reset because architectural state must read 0 after reset; a plain RAM macro could not be used here for that reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      // Ascending loop: the last scheduled update wins, so port 1 overrides port 0.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !(ZERO_REG != 0 && wa[j*AW +: AW] == '0))
          rf[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            fwd;

    assign addr = ra[i*AW +: AW];

    // fwd masks the busy flag: forwarded or hard-zero data is never stale.
    always_comb begin
      data = rf[addr];
      fwd  = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && wa[j*AW +: AW] == addr) begin
            data = wd[j*XLEN +: XLEN];
            fwd  = 1'b1;
          end
        end
      end
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
        fwd  = 1'b1;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rd_busy[i]         = busy[addr] & ~fwd;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .busy     (busy),
    .busy_any (busy_any)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, hand-written
// reset / no-bypass sequences and a randomized run against a reference model.
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                sb_flush;
  logic                busy_any;

  logic [AW-1:0]   nb_ra;
  logic [XLEN-1:0] nb_rd;
  logic            nb_rd_busy;
  logic            nb_we;
  logic [AW-1:0]   nb_wa;
  logic [XLEN-1:0] nb_wd;
  logic            nb_sb_set;
  logic [AW-1:0]   nb_sb_addr;
  logic            nb_busy_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_flush(sb_flush), .busy_any(busy_any)
  );

  regfile_mp_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1)
  ) u_nb (
    .clk(clk), .rst_n(rst_n), .ra(nb_ra), .rd(nb_rd), .rd_busy(nb_rd_busy),
    .we(nb_we), .wa(nb_wa), .wd(nb_wd), .sb_set(nb_sb_set), .sb_addr(nb_sb_addr),
    .sb_flush(1'b0), .busy_any(nb_busy_any)
  );

  // Reference model: architectural state after the last clock edge.
  logic [XLEN-1:0] m_rf   [NREGS];
  logic            m_busy [NREGS];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        sset;
    logic [4:0]  saddr;
    logic        flush;
    logic [4:0]  ra0, ra1;
    logic [31:0] erd0, erd1;
    logic        eb0, eb1, eany;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic s,
                       input logic [4:0] sa, input logic f, input logic [4:0] r0,
                       input logic [4:0] r1);
    we = w; wa = {a1, a0}; wd = {d1, d0};
    sb_set = s; sb_addr = sa; sb_flush = f; ra = {r1, r0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && wa[j*AW +: AW] != 0) m_rf[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
    end
    if (sb_flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) m_busy[wa[j*AW +: AW]] = 1'b0;
      end
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    end
  endtask

  function automatic logic write_hit(input logic [4:0] a);
    return (we[0] && wa[4:0] == a) || (we[1] && wa[9:5] == a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0)                  return '0;
    if (we[1] && wa[9:5] == a)   return wd[63:32];
    if (we[0] && wa[4:0] == a)   return wd[31:0];
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0 || write_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic any = 1'b0;
    for (int i = 0; i < NREGS; i++) any = any | m_busy[i];
    return any;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           we     wa0 wa1 wd0           wd1           set sa  fl ra0 ra1 erd0          erd1          b0 b1 any
    vecs[0]  = '{2'b01, 7,  0,  32'h1234,     0,            0,  0,  0, 7,  7,  32'h1234,     32'h1234,     0, 0, 0};
    vecs[1]  = '{2'b11, 9,  9,  32'hA,        32'hB,        0,  0,  0, 9,  7,  32'hB,        32'h1234,     0, 0, 0};
    vecs[2]  = '{2'b00, 0,  0,  0,            0,            1,  3,  0, 9,  3,  32'hB,        0,            0, 0, 0};
    vecs[3]  = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 3,  9,  0,            32'hB,        1, 0, 1};
    vecs[4]  = '{2'b01, 3,  0,  32'h33,       0,            1,  3,  0, 3,  5,  32'h33,       0,            0, 0, 1};
    vecs[5]  = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 3,  0,  32'h33,       0,            1, 0, 1};
    vecs[6]  = '{2'b01, 3,  0,  32'h44,       0,            0,  0,  0, 3,  3,  32'h44,       32'h44,       0, 0, 1};
    vecs[7]  = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 3,  9,  32'h44,       32'hB,        0, 0, 0};
    vecs[8]  = '{2'b11, 0,  0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1,  0,  0, 0,  0,  0,            0,            0, 0, 0};
    vecs[9]  = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 0,  7,  0,            32'h1234,     0, 0, 0};
    vecs[10] = '{2'b00, 0,  0,  0,            0,            1,  4,  0, 4,  6,  0,            0,            0, 0, 0};
    vecs[11] = '{2'b00, 0,  0,  0,            0,            1,  6,  0, 4,  6,  0,            0,            1, 0, 1};
    vecs[12] = '{2'b00, 0,  0,  0,            0,            1,  8,  0, 4,  6,  0,            0,            1, 1, 1};
    vecs[13] = '{2'b00, 0,  0,  0,            0,            1,  10, 1, 8,  10, 0,            0,            1, 0, 1};
    vecs[14] = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 8,  10, 0,            0,            0, 0, 0};
    vecs[15] = '{2'b00, 0,  0,  0,            0,            0,  0,  0, 4,  6,  0,            0,            0, 0, 0};

    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1, 2);
    nb_ra = 0; nb_we = 1'b0; nb_wa = 0; nb_wd = 0; nb_sb_set = 1'b0; nb_sb_addr = 0;
    #1;
    check("reset rd0", rd[31:0], 32'h0);
    check("reset rd1", rd[63:32], 32'h0);
    check("reset rd_busy", 32'(rd_busy), 32'h0);
    check("reset busy_any", 32'(busy_any), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed vector table: combinational outputs checked before each edge.
    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].we, vecs[k].wa0, vecs[k].wa1, vecs[k].wd0, vecs[k].wd1,
            vecs[k].sset, vecs[k].saddr, vecs[k].flush, vecs[k].ra0, vecs[k].ra1);
      #2;
      check($sformatf("vec%0d rd0", k), rd[31:0], vecs[k].erd0);
      check($sformatf("vec%0d rd1", k), rd[63:32], vecs[k].erd1);
      check($sformatf("vec%0d rd_busy0", k), 32'(rd_busy[0]), 32'(vecs[k].eb0));
      check($sformatf("vec%0d rd_busy1", k), 32'(rd_busy[1]), 32'(vecs[k].eb1));
      check($sformatf("vec%0d busy_any", k), 32'(busy_any), 32'(vecs[k].eany));
      tick();
    end

    // Asynchronous reset mid-run discards state and in-flight writes/sets.
    drive(2'b01, 5, 0, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0, 5, 5);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 5, 1'b0, 5, 5);
    #2;
    check("pre-reset rd x5", rd[31:0], 32'hDEADBEEF);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 5, 5);
    #1;
    check("pre-reset busy_any", 32'(busy_any), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset rd x5", rd[31:0], 32'h0);
    check("async reset rd_busy x5", 32'(rd_busy[0]), 32'h0);
    check("async reset busy_any", 32'(busy_any), 32'h0);
    drive(2'b01, 5, 0, 32'h5555, 0, 1'b1, 5, 1'b0, 5, 5);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post-reset busy_any", 32'(busy_any), 32'h0);
    for (int a = 0; a < NREGS; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      check($sformatf("post-reset rd x%0d", a), rd[31:0], 32'h0);
      check($sformatf("post-reset rd_busy x%0d", a), 32'(rd_busy[0]), 32'h0);
    end
    tick();

    // No-bypass instance: stored value until the edge, busy not masked.
    nb_we = 1'b1; nb_wa = 7; nb_wd = 32'h1234; nb_ra = 7;
    #2;
    check("nobypass same-cycle rd", nb_rd, 32'h0);
    tick();
    nb_we = 1'b0;
    #1;
    check("nobypass next-cycle rd", nb_rd, 32'h1234);
    nb_sb_set = 1'b1; nb_sb_addr = 2; nb_ra = 2;
    #1;
    check("nobypass set not visible", 32'(nb_rd_busy), 32'h0);
    tick();
    nb_sb_set = 1'b0; nb_we = 1'b1; nb_wa = 2; nb_wd = 32'h22;
    #2;
    check("nobypass wb rd_busy unmasked", 32'(nb_rd_busy), 32'h1);
    check("nobypass wb rd old", nb_rd, 32'h0);
    check("nobypass wb busy_any", 32'(nb_busy_any), 32'h1);
    tick();
    nb_we = 1'b0;
    #1;
    check("nobypass after wb rd_busy", 32'(nb_rd_busy), 32'h0);
    check("nobypass after wb rd", nb_rd, 32'h22);
    check("nobypass after wb busy_any", 32'(nb_busy_any), 32'h0);

    // Randomized run against the reference model from a clean reset.
    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 400; k++) begin
      drive(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      #2;
      check($sformatf("rand%0d rd0", k), rd[31:0], exp_rd(ra[4:0]));
      check($sformatf("rand%0d rd1", k), rd[63:32], exp_rd(ra[9:5]));
      check($sformatf("rand%0d rd_busy0", k), 32'(rd_busy[0]), 32'(exp_busy(ra[4:0])));
      check($sformatf("rand%0d rd_busy1", k), 32'(rd_busy[1]), 32'(exp_busy(ra[9:5])));
      check($sformatf("rand%0d busy_any", k), 32'(busy_any), 32'(exp_any()));
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read pipeline register file.
- Configurable width, depth, read-port count and write-port count.
- Optional write-to-read bypass, so a value written this cycle is readable in the same cycle.
- Integrated pending-write scoreboard for hazard detection in the 5-stage pipeline: decode sets a destination busy, writeback clears it.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of combinational read ports.
- NWR, 1, number of write ports; 1 or 2.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW], where AW = $clog2(NREGS).
- rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NRD  scoreboard busy flag for each read address.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- sb_set  in  1  mark destination pending (decode issue).
- sb_addr  in  AW  destination register to mark pending.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0. Consequently rd = 0, rd_busy = 0, busy_any = 0 during and immediately after reset. Reset asserted mid-operation discards pending writes and sets in that cycle.
- Writes: on posedge clk, for each port j with we[j], rf[wa[j]] <= wd[j].
  - Same address on both ports, both enabled: the higher index wins (port 1 overrides port 0).
  - With ZERO_REG = 1, writes to address 0 are dropped.
- Reads: combinational, zero latency.
  - ZERO_REG = 1 and ra = 0 -> rd = 0.
  - Otherwise, BYPASS = 1 and some enabled write port matches ra -> rd = wd of the highest-index matching port.
  - Otherwise rd = rf[ra].
- Scoreboard: one busy bit per register, updated on posedge clk.
  - Clear: busy[wa[j]] cleared for each enabled write.
  - Set: if sb_set, busy[sb_addr] set.
  - Set and clear on the same address in the same cycle: set wins, because a new producer supersedes the completing one.
  - sb_flush: all bits 0. If sb_set is in the same cycle, flush takes priority and no bit is set.
  - ZERO_REG = 1: busy[0] held 0 and a set of address 0 is ignored.
- rd_busy[i]:
  - Equals busy[ra[i]].
  - With BYPASS = 1, it is masked to 0 when an enabled write port matches ra[i] this cycle, because the data is forwarded.
  - Not masked by an sb_set issued in the same cycle; the new busy bit is visible from the next cycle.
- busy_any: combinational OR of the registered busy vector.
- Wrap/boundary:
  - Addresses are exactly AW bits wide, so no out-of-range access is possible.
  - NREGS = 2 must elaborate.
  - NWR = 1 elaborates without port-1 logic.
- Elaboration: NWR outside {1,2} or NREGS not a power of two fails via $error in an initial/generate check.

Decomposition:
- Package regfile_pkg: default XLEN/NREGS constants, and the AW derivation function (clog2 wrapper) shared with the hazard unit.
- Sub-module regfile_scoreboard: busy vector, set/clear/flush priority and busy_any. Parametrised by NREGS, NWR and ZERO_REG.
- The data array, write priority and bypass muxes stay in the top module.

Test Plan:
- Reset: drive rst_n = 0 mid-run after writing x5 = 0xDEADBEEF -> immediately rd(ra = 5) = 0 and busy_any = 0; after release, reads of all addresses return 0.
- Bypass:
  - BYPASS = 1, we[0] = 1, wa = 7, wd = 0x1234, ra0 = 7 in the same cycle -> rd0 = 0x1234 combinationally.
  - BYPASS = 0, same stimulus -> rd0 = old value 0; next cycle rd0 = 0x1234.
- Dual write collision: NWR = 2, both ports write x9 with 0xA and 0xB -> rf[9] = 0xB and bypass read returns 0xB.
- Zero register: write x0 = 0xFFFF_FFFF plus sb_set to addr 0 -> rd(ra = 0) = 0, rd_busy = 0, busy_any stays 0.
- Scoreboard:
  - sb_set x3 -> next cycle rd_busy(ra = 3) = 1.
  - Writeback we to x3 in the same cycle as sb_set x3 -> busy stays 1.
  - Later writeback alone -> busy 0; in that writeback cycle rd_busy = 0 with BYPASS = 1.
- Flush: set x4, x6, x8 on successive cycles, then sb_flush together with sb_set x10 -> next cycle all busy 0 and busy_any = 0.
